// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared constants, register offsets and state type for the frame-buffer controller
package vga_fb_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [7:0] OFF_X    = 8'd0;
  localparam logic [7:0] OFF_Y    = 8'd1;
  localparam logic [7:0] OFF_PIX  = 8'd2;
  localparam logic [7:0] OFF_COL1 = 8'd3;
  localparam logic [7:0] OFF_COL0 = 8'd4;
  localparam logic [7:0] OFF_CMD  = 8'd5;
  localparam logic [15:0] RESET_COLOURS = 16'h00FF;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/vga_fb_cursor.sv
// vga_fb_cursor: X/Y raster position with clamped loads, raster-order increment and last-pixel flag
module vga_fb_cursor #(
  parameter int W = vga_fb_pkg::SCREEN_W,
  parameter int H = vga_fb_pkg::SCREEN_H
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       i_clr,
  input  logic       i_ld_x,
  input  logic       i_ld_y,
  input  logic [7:0] i_data,
  input  logic       i_inc,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic [7:0] o_nx,
  output logic [6:0] o_ny,
  output logic       o_last
);
  localparam logic [7:0] X_MAX = 8'(W - 1);
  localparam logic [6:0] Y_MAX = 7'(H - 1);
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [7:0] w_ld_x;
  logic [6:0] w_ld_y;
  logic       w_x_end;
  // Out-of-range loads snap to 0; successor wraps X then Y in raster order
  always_comb begin
    w_x_end = r_x == X_MAX;
    w_ld_x  = i_data >= 8'(W) ? 8'd0 : i_data;
    w_ld_y  = i_data[6:0] >= 7'(H) ? 7'd0 : i_data[6:0];
    o_nx    = w_x_end ? 8'd0 : r_x + 8'd1;
    o_ny    = !w_x_end ? r_y : (r_y == Y_MAX ? 7'd0 : r_y + 7'd1);
    o_last  = w_x_end && r_y == Y_MAX;
  end
  // Position register: clear beats load beats increment
  always_ff @(posedge CLK) begin
    if (RESET || i_clr) begin
      r_x <= 8'd0;
      r_y <= 7'd0;
    end else begin
      r_x <= i_ld_x ? w_ld_x : (i_inc ? o_nx : r_x);
      r_y <= i_ld_y ? w_ld_y : (i_inc ? o_ny : r_y);
    end
  end
  assign o_x = r_x;
  assign o_y = r_y;
endmodule

// File: rtl/vga_fb_controller.sv
// vga_fb_controller: bus register decode, clear/fill sweep and frame-buffer write-port arbitration
module vga_fb_controller #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int SCREEN_W = vga_fb_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_fb_pkg::SCREEN_H
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  input  logic [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic [15:0] CONFIG_COLOURS,
  output logic        BUSY,
  output logic        CLR_DONE
);
  import vga_fb_pkg::*;
  state_t     r_state, w_next;
  logic       r_fill;
  logic [7:0] w_off;
  logic       w_ld_x, w_ld_y, w_pix, w_start, w_step, w_done;
  logic [7:0] w_cur_x, w_cur_nx, w_swp_x, w_swp_nx;
  logic [6:0] w_cur_y, w_cur_ny, w_swp_y, w_swp_ny;
  logic       w_cur_last, w_swp_last, w_unused;

  vga_fb_cursor #(.W(SCREEN_W), .H(SCREEN_H)) u_cur (
    .CLK(CLK), .RESET(RESET), .i_clr(1'b0), .i_ld_x(w_ld_x), .i_ld_y(w_ld_y),
    .i_data(BUS_DATA), .i_inc(w_pix), .o_x(w_cur_x), .o_y(w_cur_y),
    .o_nx(w_cur_nx), .o_ny(w_cur_ny), .o_last(w_cur_last)
  );

  // Sweep counter holds the last address the clear engine issued
  vga_fb_cursor #(.W(SCREEN_W), .H(SCREEN_H)) u_swp (
    .CLK(CLK), .RESET(RESET), .i_clr(w_start), .i_ld_x(1'b0), .i_ld_y(1'b0),
    .i_data(8'd0), .i_inc(w_step), .o_x(w_swp_x), .o_y(w_swp_y),
    .o_nx(w_swp_nx), .o_ny(w_swp_ny), .o_last(w_swp_last)
  );

  assign w_unused = ^{w_cur_nx, w_cur_ny, w_cur_last, w_swp_x, w_swp_y};

  // Decode the bus write and decide who owns the frame-buffer port this cycle
  always_comb begin
    w_off   = BUS_ADDR - BASE_ADDR;
    w_ld_x  = BUS_WE && w_off == OFF_X;
    w_ld_y  = BUS_WE && w_off == OFF_Y;
    w_pix   = BUS_WE && w_off == OFF_PIX;
    w_start = BUS_WE && w_off == OFF_CMD && BUS_DATA[0] && r_state == IDLE;
    w_step  = r_state == CLEAR && !w_swp_last && !w_pix;
    w_done  = r_state == CLEAR && w_swp_last;
    w_next  = r_state;
    if (w_start) w_next = CLEAR;
    if (w_done) w_next = IDLE;
  end

  // State register
  always_ff @(posedge CLK) begin
    r_state <= RESET ? IDLE : w_next;
  end

  // Registered write port, colours and status; the start command issues pixel 0 directly
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FB_ADDR        <= 15'd0;
      FB_DATA        <= 1'b0;
      FB_WE          <= 1'b0;
      CONFIG_COLOURS <= RESET_COLOURS;
      BUSY           <= 1'b0;
      CLR_DONE       <= 1'b0;
      r_fill         <= 1'b0;
    end else begin
      FB_WE               <= w_pix || w_start || w_step;
      FB_ADDR             <= w_pix ? {w_cur_y, w_cur_x} : (w_step ? {w_swp_ny, w_swp_nx} : 15'd0);
      FB_DATA             <= w_pix ? BUS_DATA[0] : (w_start ? BUS_DATA[1] : w_step && r_fill);
      r_fill              <= w_start ? BUS_DATA[1] : r_fill;
      CONFIG_COLOURS[7:0] <= BUS_WE && w_off == OFF_COL1 ? BUS_DATA : CONFIG_COLOURS[7:0];
      CONFIG_COLOURS[15:8] <= BUS_WE && w_off == OFF_COL0 ? BUS_DATA : CONFIG_COLOURS[15:8];
      BUSY                <= w_next == CLEAR;
      CLR_DONE            <= w_done;
    end
  end
endmodule
